pipeline_trace_buffer: RTL

//  On-chip circular trace capture of the pipeline's decode instruction and writeback result. Sits beside
//  the pipelined ARM core, on the same clk. Replaces per-cycle bench printing with a triggerable buffer

---
 rtl/pipeline_trace_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/pipeline_trace_buffer.sv
// Circular trace buffer for decode instruction / writeback result with a programmable post-trigger window.
// Optional build macro TRACE_STALL_FILTER_EN drops stalled cycles from capture and trigger matching.
module pipeline_trace_buffer #(
    parameter int INSTR_W   = 26,
    parameter int DATA_W    = 32,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               arm,
    input  logic               abort,
    input  logic               stall,
    input  logic [INSTR_W-1:0] instr_d,
    input  logic [DATA_W-1:0]  result_w,
    input  logic [INSTR_W-1:0] trig_mask,
    input  logic [INSTR_W-1:0] trig_value,
    input  logic [AW-1:0]      rd_addr,
    output logic [INSTR_W-1:0] rd_instr,
    output logic [DATA_W-1:0]  rd_data,
    output logic [AW:0]        count,
    output logic               triggered,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] POST_CNT = (AW+1)'(POST_TRIG);

    state_t             state_q, state_d;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic [AW:0]        post_q, post_d;
    logic               triggered_q, triggered_d;
    logic [INSTR_W-1:0] rd_instr_q, rd_instr_d;
    logic [DATA_W-1:0]  rd_data_q, rd_data_d;

    logic [INSTR_W-1:0] mem_instr [DEPTH];
    logic [DATA_W-1:0]  mem_data  [DEPTH];

    logic               sample_ok;
    logic               capturing;
    logic               wr_en;
    logic               match;
    logic [AW-1:0]      oldest;
    logic [AW-1:0]      phys;
    logic               rd_valid;

`ifdef TRACE_STALL_FILTER_EN
    assign sample_ok = !stall;
`else
    logic unused_stall;
    assign unused_stall = stall;
    assign sample_ok    = 1'b1;
`endif

    assign capturing = (state_q == ARMED) || (state_q == POST);
    assign wr_en     = capturing && !abort && sample_ok;
    assign match     = ((instr_d ^ trig_value) & trig_mask) == '0;

    // Once the buffer has wrapped, the slot about to be overwritten holds the oldest entry.
    assign oldest   = (count_q == FULL_CNT) ? wr_ptr_q : '0;
    assign phys     = oldest + rd_addr;
    assign rd_valid = {1'b0, rd_addr} < count_q;

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        post_d      = post_q;
        triggered_d = triggered_q;
        rd_instr_d  = rd_valid ? mem_instr[phys] : '0;
        rd_data_d   = rd_valid ? mem_data[phys]  : '0;

        if (abort) begin
            state_d = IDLE;
        end else if (arm && (state_q == IDLE || state_q == DONE)) begin
            state_d     = ARMED;
            wr_ptr_d    = '0;
            count_d     = '0;
            post_d      = '0;
            triggered_d = 1'b0;
        end else if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            if (count_q != FULL_CNT) begin
                count_d = count_q + 1'b1;
            end
            if (state_q == ARMED) begin
                if (match) begin
                    triggered_d = 1'b1;
                    post_d      = '0;
                    state_d     = (POST_TRIG == 0) ? DONE : POST;
                end
            end else begin
                post_d = post_q + 1'b1;
                if (post_d == POST_CNT) begin
                    state_d = DONE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            post_q      <= '0;
            triggered_q <= 1'b0;
            rd_instr_q  <= '0;
            rd_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            post_q      <= post_d;
            triggered_q <= triggered_d;
            rd_instr_q  <= rd_instr_d;
            rd_data_q   <= rd_data_d;
        end
    end

    // Storage is deliberately not reset; count gates every read instead.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_instr[wr_ptr_q] <= instr_d;
            mem_data[wr_ptr_q]  <= result_w;
        end
    end

    assign rd_instr  = rd_instr_q;
    assign rd_data   = rd_data_q;
    assign count     = count_q;
    assign triggered = triggered_q;
    assign done      = (state_q == DONE);

endmodule
